// File: rtl/counter_run_arbiter.sv
// ---------------------------------------------------------------------------
// counter_run_arbiter
//
// Shares one external loadable counter between NUM_REQ requesters. Each
// requester asks for a "run": load the counter with its start value, then
// count up (mod 2^CNT_W) until the count equals its end value. Requesters are
// served round-robin. The owner gets a one-cycle done pulse when its run
// completes. Dropping the request mid-run aborts it without a done pulse.
//
// The external counter gives load priority over enable. Both controls take
// effect on the next rising clk edge.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   req           per-requester run request, held until done or abort
//   start_val     packed start values, requester i at [i*CNT_W +: CNT_W]
//   end_val       packed end values, same packing
//   grant         one-hot owner of the counter, zero when idle
//   done          one-cycle pulse to the owner when its run completes
//   busy          high whenever the arbiter is not idle
//   cnt_load_en   counter load strobe
//   cnt_load_val  counter load value (zero when not loading)
//   cnt_enable    counter increment enable
//   cnt_count     current counter value
// ---------------------------------------------------------------------------
module counter_run_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] start_val,
    input  logic [NUM_REQ*CNT_W-1:0] end_val,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic                     cnt_load_en,
    output logic [CNT_W-1:0]         cnt_load_val,
    output logic                     cnt_enable,
    input  logic [CNT_W-1:0]         cnt_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;   // binary index of the grant bit
    logic [IDX_W-1:0]   last_q,  last_d;    // most recently served requester
    logic [CNT_W-1:0]   start_q, start_d;
    logic [CNT_W-1:0]   end_q,   end_d;

    // Round-robin pick: first requesting index after last_q, with wrap.
    logic             found;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;

    // NOTE: every variable driven here gets a default before any branch, so
    // no path leaves one unassigned and no latch is inferred.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((int'(last_q) + off) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    logic owner_req;
    assign owner_req = req[owner_q];

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_d       = last_q;
        start_d      = start_q;
        end_d        = end_q;
        done         = '0;
        cnt_load_en  = 1'b0;
        cnt_load_val = '0;
        cnt_enable   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = LOAD;
                    grant_d = NUM_REQ'(1) << pick;
                    owner_d = pick;
                    // The winner's values are captured only here; later
                    // changes on its inputs do not affect the run.
                    start_d = start_val[int'(pick)*CNT_W +: CNT_W];
                    end_d   = end_val[int'(pick)*CNT_W +: CNT_W];
                end
            end

            LOAD: begin
                // The load is issued even when this cycle turns out to be
                // an abort, so the counter always ends up holding start_q.
                cnt_load_en  = 1'b1;
                cnt_load_val = start_q;
                if (!owner_req) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                end else begin
                    state_d = RUN;
                end
            end

            RUN: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                end else if (cnt_count == end_q) begin
                    // Enable stays low on the terminal cycle, so the count
                    // stops exactly at end_q.
                    state_d = DONE;
                end else begin
                    cnt_enable = 1'b1;
                end
            end

            DONE: begin
                done    = grant_q;
                state_d = IDLE;
                grant_d = '0;
                last_d  = owner_q;
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            // Pointing at the last requester gives req[0] first priority.
            last_q  <= IDX_W'(NUM_REQ - 1);
            start_q <= '0;
            end_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            start_q <= start_d;
            end_q   <= end_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_counter_run_arbiter.sv
// ---------------------------------------------------------------------------
// tb_counter_run_arbiter
//
// Self-checking bench for counter_run_arbiter. A 4-bit loadable counter model
// closes the loop on the cnt_* ports. Each expected run (owner, start, end and
// whether it should complete) is pushed to a queue when the stimulus is set
// up. A monitor pops an entry on every new grant and checks the done pulse
// against it: index, latency, enable-cycle count and final count.
// ---------------------------------------------------------------------------
module tb_counter_run_arbiter;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] start_val;
    logic [NUM_REQ*CNT_W-1:0] end_val;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic                     cnt_load_en;
    logic [CNT_W-1:0]         cnt_load_val;
    logic                     cnt_enable;
    logic [CNT_W-1:0]         cnt;

    always #5 clk = ~clk;

    counter_run_arbiter #(
        .NUM_REQ (NUM_REQ),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .start_val    (start_val),
        .end_val      (end_val),
        .grant        (grant),
        .done         (done),
        .busy         (busy),
        .cnt_load_en  (cnt_load_en),
        .cnt_load_val (cnt_load_val),
        .cnt_enable   (cnt_enable),
        .cnt_count    (cnt)
    );

    // Loadable counter: reset 0, load has priority over enable.
    always @(posedge clk) begin
        if (rst)              cnt <= '0;
        else if (cnt_load_en) cnt <= cnt_load_val;
        else if (cnt_enable)  cnt <= cnt + 1'b1;
    end

    typedef struct {
        int idx;
        int s;
        int e;
        bit completes;
    } run_t;

    run_t exp_q[$];
    run_t cur;
    bit   cur_valid    = 0;
    bit   pending_done = 0;
    int   grant_cyc    = 0;
    int   en_cnt       = 0;
    int   cyc          = 0;
    int   n_vec        = 0;
    int   n_bad        = 0;
    logic [NUM_REQ-1:0] grant_prev = '0;
    logic               busy_prev  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        int k;
        cyc++;
        check("grant_onehot", $countones(grant) <= 1, 1);
        check("done_onehot", $countones(done) <= 1, 1);
        check("done_in_grant", done & ~grant, 0);
        check("load_and_enable", cnt_load_en & cnt_enable, 0);
        check("busy_vs_grant", busy, grant != '0);
        if (!cnt_load_en) check("load_val_idle", cnt_load_val, 0);

        if (grant != '0 && grant_prev == '0) begin
            check("idle_before_grant", busy_prev, 0);
            check("missing_done", pending_done, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_grant", grant, 0);
                cur_valid    = 0;
                pending_done = 0;
            end else begin
                cur = exp_q.pop_front();
                check("grant_idx", grant, 32'(1) << cur.idx);
                cur_valid    = 1;
                pending_done = cur.completes;
                grant_cyc    = cyc;
                en_cnt       = 0;
            end
        end

        if (cnt_load_en && cur_valid) check("load_val", cnt_load_val, cur.s);
        if (cnt_enable) en_cnt++;

        if (done != '0) begin
            if (!pending_done) begin
                check("unexpected_done", done, 0);
            end else begin
                k = (cur.e - cur.s) & ((1 << CNT_W) - 1);
                check("done_idx", done, 32'(1) << cur.idx);
                check("done_latency", cyc - grant_cyc + 1, k + 3);
                check("enable_cycles", en_cnt, k);
                check("final_count", cnt, cur.e);
                pending_done = 0;
            end
        end

        grant_prev = grant;
        busy_prev  = busy;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_vals(input int i, input int s, input int e);
        start_val[i*CNT_W +: CNT_W] = CNT_W'(s);
        end_val[i*CNT_W +: CNT_W]   = CNT_W'(e);
    endtask

    task automatic expect_run(input int i, input int s, input int e, input bit completes);
        run_t r;
        r.idx       = i;
        r.s         = s;
        r.e         = e;
        r.completes = completes;
        exp_q.push_back(r);
    endtask

    // Returns on the falling edge of the cycle in which done is seen.
    task automatic wait_done(input int max_cycles);
        bit seen = 0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            if (done != '0) seen = 1;
        end
        check("done_timeout", seen, 1);
    endtask

    task automatic wait_grant(input int max_cycles);
        bit seen = 0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            if (grant != '0) seen = 1;
        end
        check("grant_timeout", seen, 1);
    endtask

    // Completes a single run and withdraws the request as the arbiter
    // returns to idle, so the same requester is not granted again.
    task automatic finish_run();
        wait_done(40);
        @(posedge clk);
        #1;
        req = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_load_en"}, cnt_load_en, 0);
        check({tag, "_load_val"}, cnt_load_val, 0);
        check({tag, "_enable"}, cnt_enable, 0);
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        start_val = '0;
        end_val   = '0;

        // Reset with every request high, then full contention.
        set_vals(0, 3, 7);
        set_vals(1, 14, 2);
        set_vals(2, 5, 5);
        set_vals(3, 9, 1);
        req = 4'b1111;
        expect_run(0, 3, 7, 1);
        expect_run(1, 14, 2, 1);
        expect_run(2, 5, 5, 1);
        expect_run(3, 9, 1, 1);
        tick(2);
        check_all_zero("reset");
        rst = 1'b0;
        tick(1);
        check("first_grant", grant, 4'b0001);
        for (int r = 0; r < 4; r++) wait_done(40);
        @(posedge clk);
        #1;
        req = '0;
        tick(3);
        check("idle_after_contention", busy, 0);

        // Single run 3 -> 7 on requester 0; the count must hold afterwards.
        set_vals(0, 3, 7);
        expect_run(0, 3, 7, 1);
        req = 4'b0001;
        finish_run();
        tick(3);
        check("hold_count_7", cnt, 7);

        // Wrapping run 14 -> 2 on requester 1.
        set_vals(1, 14, 2);
        expect_run(1, 14, 2, 1);
        req = 4'b0010;
        finish_run();
        tick(2);
        check("hold_count_2", cnt, 2);

        // Zero-length run 5 -> 5 on requester 2.
        set_vals(2, 5, 5);
        expect_run(2, 5, 5, 1);
        req = 4'b0100;
        finish_run();
        tick(2);

        // Abort: requester 3 drops on the second RUN cycle of 3 -> 10.
        set_vals(3, 3, 10);
        expect_run(3, 3, 10, 0);
        expect_run(0, 3, 7, 0);
        req = 4'b1000;
        wait_grant(20);
        tick(2);
        req = 4'b0001;
        #1;
        check("abort_enable", cnt_enable, 0);
        check("abort_busy", busy, 1);
        tick(1);
        check("abort_idle_busy", busy, 0);
        check("abort_idle_grant", grant, 0);
        check("abort_hold_count", cnt, 4);
        tick(1);
        check("after_abort_grant", grant, 4'b0001);

        // Reset in the middle of requester 0's run.
        tick(2);
        check("pre_reset_busy", busy, 1);
        rst = 1'b1;
        req = '0;
        tick(1);
        check_all_zero("midrun_reset");
        rst = 1'b0;
        tick(10);

        check("sb_empty", exp_q.size(), 0);
        check("no_pending_done", pending_done, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
